// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one memory-mapped UART transmitter
// among NUM_REQ byte producers. Each grant moves one byte. The byte is
// written only after a status read has returned "buffer empty" (bit 0).
// The transmitter acknowledge is registered and lingers one extra cycle, so
// a masking gap cycle separates every pair of bus transactions.
// Optional feature macro: LINE_LOCK_EN. When it is defined, a requester keeps
// the grant until it sends 8'h0A or drops req_valid, so text lines are not
// interleaved.

module uart_tx_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] UART_ADDR = 32'h0200_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_enable,
  output logic                 uart_mem_valid,
  output logic [3:0]           uart_mem_wstrb,
  output logic [31:0]          uart_mem_wdata,
  output logic [31:0]          uart_mem_addr,
  input  logic [31:0]          uart_mem_rdata,
  input  logic                 uart_mem_ready,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POLL  = 3'd1,
    ST_GAP_P = 3'd2,
    ST_GAP_W = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [2:0]           rr_ptr_r;
  logic [2:0]           grant_id_r;
  logic [31:0]          wdata_r;
  logic [NUM_REQ-1:0]   req_ready_r;
  logic                 enable_r;
  logic                 valid_r;
  logic [3:0]           wstrb_r;
  logic                 busy_r;

  logic [NUM_REQ-1:0]   req_ready_nxt_s;
  logic                 enable_nxt_s;
  logic                 valid_nxt_s;
  logic [3:0]           wstrb_nxt_s;
  logic                 busy_nxt_s;

  logic [7:0]           valid_pad_s;
  logic [63:0]          data_pad_s;
  logic [7:0]           gnt_byte_s;
  logic [7:0]           onehot_s;
  logic [2:0]           gid_plus1_s;
  logic [2:0]           search_base_s;
  logic [2:0]           gnt_idx_s;
  logic                 gnt_found_s;
  logic [3:0]           cand_s;
  logic                 unused_rdata_s;

`ifdef LINE_LOCK_EN
  logic                 lock_r;
`endif

  // Requester vectors padded to the 8-requester maximum so 3-bit indices are always in range.
  assign valid_pad_s    = 8'(req_valid);
  assign data_pad_s     = 64'(req_data);
  assign gnt_byte_s     = data_pad_s[{gnt_idx_s, 3'b000} +: 8];
  assign unused_rdata_s = ^uart_mem_rdata[31:1];

  // Successor of the current grant, wrapping at NUM_REQ.
  always_comb begin
    if (grant_id_r == 3'(NUM_REQ - 1)) begin
      gid_plus1_s = 3'd0;
    end else begin
      gid_plus1_s = grant_id_r + 3'd1;
    end
  end

  // Round-robin search for the first valid requester at or after the search base.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = 3'd0;
    cand_s      = 4'd0;
`ifdef LINE_LOCK_EN
    if (lock_r) begin
      search_base_s = gid_plus1_s;
    end else begin
      search_base_s = rr_ptr_r;
    end
`else
    search_base_s = rr_ptr_r;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, search_base_s} + 4'(k);
      if (cand_s >= 4'(NUM_REQ)) begin
        cand_s = cand_s - 4'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && valid_pad_s[cand_s[2:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s[2:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
`ifdef LINE_LOCK_EN
    // A locked requester that still has data overrides the round-robin choice.
    if (lock_r && valid_pad_s[grant_id_r]) begin
      gnt_found_s = 1'b1;
      gnt_idx_s   = grant_id_r;
    end else begin
      gnt_idx_s   = gnt_idx_s;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; acknowledge is ignored in the gap and done cycles.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_found_s) begin
          state_nxt_s = ST_POLL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_POLL: begin
        if (uart_mem_ready) begin
          if (uart_mem_rdata[0]) begin
            state_nxt_s = ST_GAP_W;
          end else begin
            state_nxt_s = ST_GAP_P;
          end
        end else begin
          state_nxt_s = ST_POLL;
        end
      end
      ST_GAP_P: state_nxt_s = ST_POLL;
      ST_GAP_W: state_nxt_s = ST_WRITE;
      ST_WRITE: begin
        if (uart_mem_ready) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode, computed from the next state so the outputs can be registered.
  always_comb begin
    onehot_s        = 8'd1 << grant_id_r;
    req_ready_nxt_s = {NUM_REQ{1'b0}};
    enable_nxt_s    = 1'b0;
    valid_nxt_s     = 1'b0;
    wstrb_nxt_s     = 4'b0000;
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    case (state_nxt_s)
      ST_POLL: begin
        enable_nxt_s = 1'b1;
        valid_nxt_s  = 1'b1;
        wstrb_nxt_s  = 4'b0000;
      end
      ST_WRITE: begin
        enable_nxt_s = 1'b1;
        valid_nxt_s  = 1'b1;
        wstrb_nxt_s  = 4'b0001;
      end
      ST_DONE: begin
        req_ready_nxt_s = onehot_s[NUM_REQ-1:0];
      end
      default: begin
        enable_nxt_s = 1'b0;
        valid_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered bus and handshake outputs; async reset drops the bus request at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_ready_r <= {NUM_REQ{1'b0}};
      enable_r    <= 1'b0;
      valid_r     <= 1'b0;
      wstrb_r     <= 4'b0000;
      busy_r      <= 1'b0;
    end else begin
      req_ready_r <= req_ready_nxt_s;
      enable_r    <= enable_nxt_s;
      valid_r     <= valid_nxt_s;
      wstrb_r     <= wstrb_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Grant capture (byte and id latched in IDLE) and round-robin pointer update in DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_id_r <= 3'd0;
      wdata_r    <= 32'd0;
      rr_ptr_r   <= 3'd0;
`ifdef LINE_LOCK_EN
      lock_r     <= 1'b0;
`endif
    end else begin
      if ((state_r == ST_IDLE) && gnt_found_s) begin
        grant_id_r <= gnt_idx_s;
        wdata_r    <= {24'd0, gnt_byte_s};
      end else begin
        grant_id_r <= grant_id_r;
        wdata_r    <= wdata_r;
      end
`ifdef LINE_LOCK_EN
      if (state_r == ST_DONE) begin
        if (wdata_r[7:0] == 8'h0A) begin
          lock_r   <= 1'b0;
          rr_ptr_r <= gid_plus1_s;
        end else begin
          lock_r   <= 1'b1;
          rr_ptr_r <= rr_ptr_r;
        end
      end else if ((state_r == ST_IDLE) && lock_r && !valid_pad_s[grant_id_r]) begin
        lock_r   <= 1'b0;
        rr_ptr_r <= gid_plus1_s;
      end else begin
        lock_r   <= lock_r;
        rr_ptr_r <= rr_ptr_r;
      end
`else
      if (state_r == ST_DONE) begin
        rr_ptr_r <= gid_plus1_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
`endif
    end
  end

  assign req_ready      = req_ready_r;
  assign uart_enable    = enable_r;
  assign uart_mem_valid = valid_r;
  assign uart_mem_wstrb = wstrb_r;
  assign uart_mem_wdata = wdata_r;
  assign uart_mem_addr  = UART_ADDR;
  assign grant_id       = grant_id_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues, a registered-acknowledge
// transmitter model with a configurable number of "full" status replies, and
// a scoreboard of expected (requester, byte, status-read count) per write.

module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic              clk;
  logic              resetn;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              uart_enable;
  logic              uart_mem_valid;
  logic [3:0]        uart_mem_wstrb;
  logic [31:0]       uart_mem_wdata;
  logic [31:0]       uart_mem_addr;
  logic [31:0]       uart_mem_rdata;
  logic              uart_mem_ready;
  logic [2:0]        grant_id;
  logic              busy;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .UART_ADDR (32'h0200_0000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .uart_enable    (uart_enable),
    .uart_mem_valid (uart_mem_valid),
    .uart_mem_wstrb (uart_mem_wstrb),
    .uart_mem_wdata (uart_mem_wdata),
    .uart_mem_addr  (uart_mem_addr),
    .uart_mem_rdata (uart_mem_rdata),
    .uart_mem_ready (uart_mem_ready),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Requester byte queues
  logic [7:0] rq_mem [NR][8];
  int         rq_head [NR];
  int         rq_tail [NR];
  int         vld_cyc [NR];

  task automatic load(input int id, input logic [7:0] b);
    rq_mem[id][rq_tail[id][2:0]] = b;
    rq_tail[id]++;
  endtask

  task automatic clear_bufs();
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
  endtask

  // Scoreboard
  typedef struct {
    int         id;
    logic [7:0] data;
    int         polls;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  task automatic expect_byte(input int id, input logic [7:0] b, input int polls);
    exp_t e;
    e.id    = id;
    e.data  = b;
    e.polls = polls;
    exp_q.push_back(e);
  endtask

  // Requester driver: pops on req_ready, keeps valid/data stable otherwise
  initial begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
      vld_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && (rq_head[i] != rq_tail[i])) rq_head[i]++;
        if (rq_head[i] != rq_tail[i]) begin
          if (!req_valid[i]) vld_cyc[i] = cyc;
          req_valid[i]         = 1'b1;
          req_data[8*i +: 8]   = rq_mem[i][rq_head[i][2:0]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: ack one cycle after valid, held one extra cycle
  int   full_left;
  int   rdy_cnt;
  logic m_v, m_r, m_st;
  initial begin
    uart_mem_ready = 1'b0;
    uart_mem_rdata = 32'd1;
    full_left      = 0;
    rdy_cnt        = 0;
    forever begin
      @(negedge clk);
      m_v  = uart_mem_valid && resetn;
      m_r  = uart_mem_ready;
      m_st = m_v && m_r && (uart_mem_wstrb == 4'b0000);
      @(posedge clk);
      #1;
      if (!resetn) begin
        uart_mem_ready = 1'b0;
        rdy_cnt        = 0;
      end else if (rdy_cnt != 0) begin
        uart_mem_ready = 1'b1;
        rdy_cnt--;
      end else if (m_v && !m_r) begin
        uart_mem_ready = 1'b1;
        rdy_cnt        = 1;
      end else begin
        uart_mem_ready = 1'b0;
      end
      if (m_st && (full_left > 0)) full_left--;
      uart_mem_rdata = {31'd0, (full_left == 0)};
    end
  end

  // Monitor: bus handshakes and req_ready pulses against the scoreboard
  int   poll_cnt;
  logic status_empty;
  logic prev_hs;
  logic hs;
  int   rdy_cyc;
  int   done_id;
  exp_t mon_e;
  initial begin
    poll_cnt     = 0;
    status_empty = 1'b0;
    prev_hs      = 1'b0;
    rdy_cyc      = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        poll_cnt     = 0;
        status_empty = 1'b0;
        prev_hs      = 1'b0;
      end else begin
        if (prev_hs) chk("gap_valid_low", 32'(uart_mem_valid), 32'd0);
        hs = uart_mem_valid && uart_mem_ready;
        if (hs && (uart_mem_wstrb == 4'b0000)) begin
          poll_cnt++;
          status_empty = uart_mem_rdata[0];
        end else if (hs) begin
          chk("write_wstrb", 32'(uart_mem_wstrb), 32'd1);
          chk("write_after_empty", 32'(status_empty), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(uart_mem_wdata), 32'hFFFF_FFFF);
          end else begin
            mon_e = exp_q.pop_front();
            chk("write_data", uart_mem_wdata, {24'd0, mon_e.data});
            chk("write_grant_id", 32'(grant_id), 32'(mon_e.id));
            chk("status_reads", 32'(poll_cnt), 32'(mon_e.polls));
            done_q.push_back(mon_e.id);
          end
          poll_cnt     = 0;
          status_empty = 1'b0;
        end
        if (req_ready != '0) begin
          if (done_q.size() == 0) begin
            chk("unexpected_req_ready", 32'(req_ready), 32'd0);
          end else begin
            done_id = done_q.pop_front();
            chk("req_ready_onehot", 32'(req_ready), 32'd1 << done_id);
            rdy_cyc = cyc;
          end
        end
        prev_hs = hs;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (((exp_q.size() != 0) || (done_q.size() != 0)) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size() + done_q.size());
      exp_q.delete();
      done_q.delete();
    end else begin
      repeat (2) @(negedge clk);
      chk("idle_after_drain", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_bufs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Main sequence
  initial begin
    int n;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_enable", 32'(uart_enable), 32'd0);
    chk("rst_valid", 32'(uart_mem_valid), 32'd0);
    chk("rst_wstrb", 32'(uart_mem_wstrb), 32'd0);
    chk("rst_wdata", uart_mem_wdata, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("addr_const", uart_mem_addr, 32'h0200_0000);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, empty transmitter: req_valid cycle through req_ready cycle = 7
    expect_byte(2, 8'h41, 1);
    load(2, 8'h41);
    drain();
    chk("latency_cycles", 32'(rdy_cyc - vld_cyc[2] + 1), 32'd7);

    // Contention from reset: 10, 11, 12, 13
    do_reset();
    for (int i = 0; i < NR; i++) begin
      expect_byte(i, 8'(8'h10 + i), 1);
      load(i, 8'(8'h10 + i));
    end
    drain();

    // Busy transmitter: three full replies, then empty
    full_left = 3;
    expect_byte(1, 8'h55, 4);
    load(1, 8'h55);
    drain();
    chk("full_replies_used", 32'(full_left), 32'd0);

    // Reset during WRITE, then the byte is re-presented and sent once
    expect_byte(3, 8'h77, 1);
    load(3, 8'h77);
    n = 0;
    while (!(uart_mem_valid && (uart_mem_wstrb == 4'b0001) && !uart_mem_ready) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk("write_state_reached", 32'(n < 100), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_valid_drop", 32'(uart_mem_valid), 32'd0);
    chk("async_enable_drop", 32'(uart_mem_enable_or_zero()), 32'd0);
    chk("async_busy_drop", 32'(busy), 32'd0);
    chk("async_no_ready", 32'(req_ready), 32'd0);
    clear_bufs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    load(3, 8'h77);
    drain();

    // Line test: requester 0 sends "AB\n", requester 1 holds 8'h5A
`ifdef LINE_LOCK_EN
    expect_byte(0, 8'h41, 1);
    expect_byte(0, 8'h42, 1);
    expect_byte(0, 8'h0A, 1);
    expect_byte(1, 8'h5A, 1);
`else
    expect_byte(0, 8'h41, 1);
    expect_byte(1, 8'h5A, 1);
    expect_byte(0, 8'h42, 1);
    expect_byte(0, 8'h0A, 1);
`endif
    load(0, 8'h41);
    load(0, 8'h42);
    load(0, 8'h0A);
    load(1, 8'h5A);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic uart_mem_enable_or_zero();
    return uart_enable;
  endfunction

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single memory-mapped UART transmitter among NUM_REQ on-chip byte producers, such as a debug monitor, CPU console bridge and trace unit. Requesters arbitrate round-robin, one byte per grant. The block then acts as the transmitter's only bus master: it polls the transmitter status word until the buffer is empty, then writes the byte. A byte is written only after "buffer empty" has been read back, so no byte is ever dropped.

Parameters:
NUM_REQ, 4, number of byte requesters (2..8).
UART_ADDR, 32'h0200_0000, constant driven on uart_mem_addr.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
req_ready  output  NUM_REQ  one-cycle pulse: byte of requester i accepted
uart_enable  output  1  transmitter select
uart_mem_valid  output  1  bus request to transmitter
uart_mem_wstrb  output  4  4'b0000 = status read, 4'b0001 = byte write
uart_mem_wdata  output  32  {24'b0, byte}
uart_mem_addr  output  32  UART_ADDR
uart_mem_rdata  input  32  transmitter status; bit0 = 1 means buffer empty
uart_mem_ready  input  1  registered acknowledge from transmitter
grant_id  output  3  index of the current/last granted requester
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, RR pointer 0. All outputs 0: req_ready, uart_enable, uart_mem_valid, wstrb, wdata, grant_id, busy. uart_mem_addr is constant.
- Requester rule: hold req_valid and req_data stable until req_ready. The block latches the byte at grant.
- IDLE: if any req_valid, grant the first set bit searching from the RR pointer upward with wrap-around. Latch the byte into wdata and set grant_id. Go to POLL on the next edge.
- POLL: uart_enable=1, uart_mem_valid=1, wstrb=0. Hold until uart_mem_ready=1, then sample rdata[0] in that same cycle:
  - rdata[0]=1: next state GAP_W.
  - rdata[0]=0: next state GAP_P.
- GAP_P / GAP_W: one cycle with valid=0, enable=0, and uart_mem_ready ignored. The transmitter acknowledge is registered and stays high one extra cycle, so it must be masked here. GAP_P returns to POLL; GAP_W goes to WRITE.
- WRITE: uart_enable=1, uart_mem_valid=1, wstrb=4'b0001. Hold until uart_mem_ready=1, then go to DONE.
- DONE: valid=0 and enable=0, ready ignored. Pulse req_ready[grant_id] for exactly this cycle. RR pointer <= (grant_id+1) mod NUM_REQ. Next state IDLE.
- Minimum latency per byte with an empty transmitter and ready one cycle after valid: IDLE(1) + POLL(2) + GAP_W(1) + WRITE(2) + DONE(1) = 7 cycles from req_valid to req_ready.
- uart_mem_valid is never high in two bus transactions without an intervening low cycle.
- req_valid deasserting after grant is a protocol violation. The byte is still sent and req_ready still pulses.
- Polling has no timeout: it repeats indefinitely while the transmitter reports full.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops valid. The in-flight byte is discarded and no req_ready is issued.
- Grant is computed only in IDLE. New req_valid bits arriving mid-transaction wait for the next IDLE.

Optional Feature:
LINE_LOCK_EN.
- Defined:
  - After a granted byte other than 8'h0A, DONE keeps the grant. The RR pointer is not advanced.
  - The next IDLE serves only that requester while its req_valid is high, which keeps lines unmixed.
  - The lock releases when 8'h0A completes, or when the locked requester's req_valid is low in IDLE. Normal RR then resumes from grant_id+1.
- Undefined: arbitration is per byte, as described in Behaviour.

Test Plan:
- Single byte: req_valid[2]=1, data 8'h41, UART empty → one status read (wstrb 0), then write wdata 32'h41, wstrb 1. req_ready[2] pulses once, 7 cycles after req_valid.
- Contention: req_valid=4'b1111 with bytes 8'h10..8'h13 from reset → writes in order 10, 11, 12, 13. After DONE for 11, pointer = 2.
- Busy transmitter: rdata[0]=0 on the first 3 polls, then 1 → exactly 4 status reads, each separated by a valid-low cycle, then one write. No write occurs while the transmitter reports full.
- Ready masking: transmitter holds ready high for 2 cycles after each valid → no extra state advance and no double write (exactly one wstrb=1 transaction per byte).
- Reset mid-WRITE: resetn low during WRITE → valid=0 asynchronously, no req_ready. After release the bench re-presents the byte and it is sent exactly once.
- LINE_LOCK_EN: requester 0 sends "AB\n" while requester 1 holds 8'h5A → order 41, 42, 0A, 5A. Without the macro: 41, 5A, 42, 0A.
